hamming_secded_dec: RTL and testbench
=====================================

# hamming_secded_dec

Streaming SECDED decoder for the 16-bit Hamming block format used by the program 1/2 datapath. It accepts received codewords one byte at a time, low byte first, over a valid/ready handshake. It computes the syndrome and overall parity, corrects single-bit errors and flags double-bit errors. It emits a 16-bit status+data result as two output bytes, low byte first, in the same byte order as the program 2 result area in data memory. Per-run saturating error counters are also provided.

## Interface
- No parameters; all widths are fixed by the codeword format.
- clk  in  1  sole clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low; 0 = reset asserted
- clr  in  1  synchronous; clears both counters, does not affect the FSM
- in_valid  in  1  in_byte is valid this cycle
- in_byte  in  8  codeword byte; first beat is bits [7:0], second beat is bits [15:8]
- in_ready  out  1  decoder accepts in_byte this cycle
- out_valid  out  1  out_byte is valid this cycle
- out_byte  out  8  result byte; first beat is bits [7:0], second beat is bits [15:8]
- out_ready  in  1  downstream accepts out_byte this cycle
- cnt_single  out  8  count of single-error words, saturating at 8'hFF
- cnt_double  out  8  count of double-error words, saturating at 8'hFF

## Operation
- Codeword bit positions:
  - 0 = p0 (overall parity), 1 = p1, 2 = p2, 3 = d1, 4 = p4
  - 5..7 = d2..d4, 8 = p8, 9..15 = d5..d11
- Syndrome s[3:0]: s[k] = XOR of all codeword bits c[i], i in 1..15, whose index i has bit k set.
- Overall parity q = XOR of c[15:0].
- Classification:
  - s==0, q==0: no error. flags = 2'b00.
  - q==1: single error at position s (s==0 means p0 flipped). Invert c[s], then extract data. flags = 2'b01.
  - s!=0, q==0: double error. No correction; data is extracted from the raw codeword. flags = 2'b10.
- Result word = {flags[1:0], 3'b000, d[11:1]}.
- FSM states:
  - IN_LO: in_ready=1. On a handshake, capture the low byte and go to IN_HI.
  - IN_HI: in_ready=1. On a handshake, capture the high byte, register the decoded result, update counters, go to OUT_LO.
  - OUT_LO: out_valid=1, out_byte=result[7:0]. On a handshake, go to OUT_HI.
  - OUT_HI: out_valid=1, out_byte=result[15:8]. On a handshake, go to IN_LO.
- in_ready=0 in the OUT states; out_valid=0 in the IN states. No overlap between input and output: single-buffered.
- A handshake is valid && ready sampled high at the rising edge. When valid is low or ready is held low, the FSM stays in its state and holds all data.
- Counters:
  - cnt_single increments by 1 when a single-error word is registered (IN_HI handshake); cnt_double likewise for double-error words.
  - Both saturate at 8'hFF.
  - clr in the same cycle as an increment: clr wins and the counter reads 0 next cycle.

## Timing
- Reset values: state=IN_LO, in_ready=1, out_valid=0, out_byte=8'h00, cnt_single=0, cnt_double=0, captured bytes and result = 0.
- Reset asserted mid-word (any state) discards the partial input or pending output. No counter update occurs for that word.
- Latency: the IN_HI handshake at edge N makes out_valid=1 with the low result byte from N+1. The high byte follows on the cycle after the OUT_LO handshake.
- Full-rate throughput with valid/ready always high: 1 word per 4 cycles.
- out_byte and out_valid are registered, or decoded from registered state only. No combinational path from in_* to out_*.
- Decode logic sits between the IN_HI capture and the result register: one cycle, no multicycle paths.

## Test plan
- Clean codeword: stream 16'hFFFF (d=11'h7FF), bytes FF then FF -> out bytes FF then 07 (result 16'h07FF); counters unchanged.
- Single data-bit error: 16'h0020 (all-zero word with bit 5 flipped) -> result 16'h4000; cnt_single=1.
- Single p0 error: 16'hFFFE -> s=0, q=1 -> result 16'h47FF; cnt_single increments.
- Double error: 16'h0028 (bits 3 and 5 flipped) -> s=6, q=0 -> result 16'h8003; cnt_double=1.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles in OUT_LO -> out_byte stable and in_ready=0 throughout.
  - Assert reset after only the low byte -> next two bytes are treated as a fresh word.
- Counter edges:
  - 260 single-error words -> cnt_single=8'hFF.
  - clr together with a single-error registration -> cnt_single=0.
  - Random SECDED sweep with 15 words mixing 0/1/2 flips -> scoreboard matches the reference decode.

Source files
------------

// File: rtl/hamming_secded_dec_if.sv
// Byte-wide valid/ready streaming interface of the SECDED decoder.
// The input channel carries codeword bytes; the output channel carries result bytes.
interface hamming_secded_dec_if;
  logic       in_valid;
  logic [7:0] in_byte;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_byte;
  logic       out_ready;

  modport master (
    output in_valid, in_byte, out_ready,
    input  in_ready, out_valid, out_byte
  );

  modport slave (
    input  in_valid, in_byte, out_ready,
    output in_ready, out_valid, out_byte
  );
endinterface

// File: rtl/hamming_secded_dec.sv
// Streaming SECDED decoder for 16-bit Hamming blocks: two bytes in, two status+data bytes out.
// Single-buffered; keeps saturating per-run counts of single and double errors.
module hamming_secded_dec (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  hamming_secded_dec_if.slave   bus,
  output logic [7:0]            cnt_single,
  output logic [7:0]            cnt_double
);

  typedef enum logic [1:0] {IN_LO, IN_HI, OUT_LO, OUT_HI} state_t;

  state_t      state_r;
  logic [7:0]  lo_r;
  logic [15:0] result_r;
  logic        in_ready_r;
  logic        out_valid_r;
  logic [7:0]  out_byte_r;
  logic [7:0]  cnt_single_r;
  logic [7:0]  cnt_double_r;

  logic [15:0] code_s;
  logic [3:0]  syn_s;
  logic        q_s;
  logic [15:0] fixed_s;
  logic [1:0]  flags_s;
  logic [15:0] result_s;
  logic        word_done_s;

  // Each mask selects the positions 1..15 whose index has syndrome bit k set.
  function automatic logic [3:0] syndrome(input logic [15:0] c);
    logic [3:0] s;
    s[0] = ^(c & 16'hAAAA);
    s[1] = ^(c & 16'hCCCC);
    s[2] = ^(c & 16'hF0F0);
    s[3] = ^(c & 16'hFF00);
    return s;
  endfunction

  function automatic logic overall_parity(input logic [15:0] c);
    return ^c;
  endfunction

  assign code_s      = {bus.in_byte, lo_r};
  assign syn_s       = syndrome(code_s);
  assign q_s         = overall_parity(code_s);
  assign word_done_s = (state_r == IN_HI) && bus.in_valid && in_ready_r;

  // Classify the assembled codeword, correct a single flip and pack the result word.
  always_comb begin
    fixed_s = code_s;
    flags_s = 2'b00;
    if (q_s) begin
      fixed_s = code_s ^ (16'h0001 << syn_s);
      flags_s = 2'b01;
    end else if (syn_s != 4'h0) begin
      flags_s = 2'b10;
    end else begin
      flags_s = 2'b00;
    end
    result_s = {flags_s, 3'b000, fixed_s[15:9], fixed_s[7:5], fixed_s[3]};
  end

  // Word FSM with registered handshake outputs and result byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IN_LO;
      lo_r        <= 8'h00;
      result_r    <= 16'h0000;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_byte_r  <= 8'h00;
    end else begin
      case (state_r)
        IN_LO: begin
          if (bus.in_valid && in_ready_r) begin
            lo_r    <= bus.in_byte;
            state_r <= IN_HI;
          end
        end
        IN_HI: begin
          if (word_done_s) begin
            result_r    <= result_s;
            out_byte_r  <= result_s[7:0];
            out_valid_r <= 1'b1;
            in_ready_r  <= 1'b0;
            state_r     <= OUT_LO;
          end
        end
        OUT_LO: begin
          if (out_valid_r && bus.out_ready) begin
            out_byte_r <= result_r[15:8];
            state_r    <= OUT_HI;
          end
        end
        OUT_HI: begin
          if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IN_LO;
          end
        end
        default: begin
          state_r     <= IN_LO;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Saturating error counters; clr overrides a same-cycle increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_single_r <= 8'h00;
      cnt_double_r <= 8'h00;
    end else if (clr) begin
      cnt_single_r <= 8'h00;
      cnt_double_r <= 8'h00;
    end else if (word_done_s) begin
      if (flags_s == 2'b01 && cnt_single_r != 8'hFF) begin
        cnt_single_r <= cnt_single_r + 8'h01;
      end
      if (flags_s == 2'b10 && cnt_double_r != 8'hFF) begin
        cnt_double_r <= cnt_double_r + 8'h01;
      end
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_byte  = out_byte_r;
  assign cnt_single    = cnt_single_r;
  assign cnt_double    = cnt_double_r;

endmodule

// File: tb/tb_hamming_secded_dec.sv
// Self-checking bench for hamming_secded_dec: directed cases from the codeword rules,
// backpressure, reset mid-word, counter saturation/clear and a random SECDED sweep.
module tb_hamming_secded_dec;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] cnt_single;
  logic [7:0] cnt_double;
  int         n_assert = 0;
  int         n_fail = 0;
  int         m_single = 0;
  int         m_double = 0;

  hamming_secded_dec_if bif();

  hamming_secded_dec dut (
    .clk(clk), .reset(reset), .clr(clr), .bus(bif.slave),
    .cnt_single(cnt_single), .cnt_double(cnt_double)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_pow2(input int i);
    return (i & (i - 1)) == 0;
  endfunction

  // Build a valid codeword: data on non-power-of-two positions, parity bits zero the syndrome.
  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] c;
    int j, s;
    c = 16'h0000; j = 0; s = 0;
    for (int i = 3; i < 16; i++) begin
      if (!is_pow2(i)) begin c[i] = d[j]; j++; end
    end
    for (int i = 1; i < 16; i++) if (c[i]) s = s ^ i;
    for (int k = 0; k < 4; k++) if ((s >> k) & 1) c[1 << k] = 1'b1;
    c[0] = ($countones(c) % 2) == 1;
    return c;
  endfunction

  // Syndrome as XOR of the indices of set bits; overall parity by popcount.
  function automatic logic [15:0] ref_decode(input logic [15:0] cw);
    logic [15:0] c;
    logic [10:0] d;
    logic [1:0]  f;
    int s, q, j;
    c = cw; s = 0; j = 0;
    for (int i = 1; i < 16; i++) if (c[i]) s = s ^ i;
    q = $countones(c) % 2;
    if (q == 1) begin f = 2'b01; c[s] = ~c[s]; end
    else if (s != 0) f = 2'b10;
    else f = 2'b00;
    d = 11'h000;
    for (int i = 3; i < 16; i++) begin
      if (!is_pow2(i)) begin d[j] = c[i]; j++; end
    end
    return {f, 3'b000, d};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bif.in_valid = 1'b1;
    bif.in_byte  = b;
    while (bif.in_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    check("in_ready_timeout", {15'h0000, bif.in_ready}, 16'h0001);
    @(posedge clk); #1;
    bif.in_valid = 1'b0;
  endtask

  task automatic recv_byte(output logic [7:0] b);
    int n = 0;
    bif.out_ready = 1'b1;
    while (bif.out_valid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    check("out_valid_timeout", {15'h0000, bif.out_valid}, 16'h0001);
    b = bif.out_byte;
    @(posedge clk); #1;
    bif.out_ready = 1'b0;
  endtask

  task automatic model_count(input logic [15:0] res);
    if (res[15:14] == 2'b01 && m_single < 255) m_single++;
    if (res[15:14] == 2'b10 && m_double < 255) m_double++;
  endtask

  task automatic recv_and_check(input string tag, input logic [15:0] exp);
    logic [7:0] lo, hi;
    recv_byte(lo);
    recv_byte(hi);
    check(tag, {hi, lo}, exp);
    check({tag, "_cs"}, {8'h00, cnt_single}, m_single[15:0]);
    check({tag, "_cd"}, {8'h00, cnt_double}, m_double[15:0]);
  endtask

  task automatic run_word(input string tag, input logic [15:0] cw);
    logic [15:0] exp;
    exp = ref_decode(cw);
    send_byte(cw[7:0]);
    send_byte(cw[15:8]);
    model_count(exp);
    recv_and_check(tag, exp);
  endtask

  initial begin
    logic [15:0] cw, exp;
    logic [7:0]  held;
    int p1, p2, nflip;
    bif.in_valid = 1'b0; bif.in_byte = 8'h00; bif.out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  {15'h0000, bif.in_ready},  16'h0001);
    check("rst_out_valid", {15'h0000, bif.out_valid}, 16'h0000);
    check("rst_out_byte",  {8'h00, bif.out_byte},     16'h0000);
    check("rst_cnt",       {cnt_single, cnt_double},  16'h0000);
    reset = 1'b1;
    @(posedge clk); #1;

    // Directed words with the expected results written out
    check("ref_ffff", ref_decode(16'hFFFF), 16'h07FF);
    run_word("clean_ffff", 16'hFFFF);
    check("ref_0020", ref_decode(16'h0020), 16'h4000);
    run_word("single_d2", 16'h0020);
    check("ref_fffe", ref_decode(16'hFFFE), 16'h47FF);
    run_word("single_p0", 16'hFFFE);
    check("ref_0028", ref_decode(16'h0028), 16'h8003);
    run_word("double_3_5", 16'h0028);

    // Backpressure in OUT_LO
    cw  = encode(11'h5A3) ^ 16'h0200;
    exp = ref_decode(cw);
    send_byte(cw[7:0]);
    send_byte(cw[15:8]);
    model_count(exp);
    held = exp[7:0];
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", {15'h0000, bif.out_valid}, 16'h0001);
      check("bp_out_byte",  {8'h00, bif.out_byte},     {8'h00, held});
      check("bp_in_ready",  {15'h0000, bif.in_ready},  16'h0000);
      @(posedge clk); #1;
    end
    recv_and_check("bp_word", exp);

    // Reset after only the low byte
    send_byte(8'hAB);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    m_single = 0; m_double = 0;
    check("mid_rst_in_ready",  {15'h0000, bif.in_ready},  16'h0001);
    check("mid_rst_out_valid", {15'h0000, bif.out_valid}, 16'h0000);
    check("mid_rst_cnt",       {cnt_single, cnt_double},  16'h0000);
    run_word("after_rst", 16'h0020);

    // Saturation of cnt_single over 260 single-error words
    for (int i = 0; i < 260; i++) begin
      cw = encode(11'($urandom_range(0, 2047))) ^ (16'h0001 << $urandom_range(0, 15));
      run_word("sat_word", cw);
    end
    check("sat_cnt_single", {8'h00, cnt_single}, 16'h00FF);

    // clr coincident with a single-error registration
    cw  = encode(11'h123) ^ 16'h0400;
    exp = ref_decode(cw);
    send_byte(cw[7:0]);
    bif.in_valid = 1'b1; bif.in_byte = cw[15:8]; clr = 1'b1;
    @(posedge clk); #1;
    bif.in_valid = 1'b0; clr = 1'b0;
    m_single = 0; m_double = 0;
    check("clr_cnt_single", {8'h00, cnt_single}, 16'h0000);
    recv_and_check("clr_word", exp);

    // Random sweep mixing 0, 1 and 2 flips
    for (int i = 0; i < 15; i++) begin
      cw    = encode(11'($urandom_range(0, 2047)));
      nflip = i % 3;
      p1    = $urandom_range(0, 15);
      p2    = (p1 + 1 + $urandom_range(0, 14)) % 16;
      if (nflip >= 1) cw[p1] = ~cw[p1];
      if (nflip == 2) cw[p2] = ~cw[p2];
      run_word("rand_word", cw);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
